i8008_bus_ctrl: RTL and testbench

Bus-cycle controller between `i8008_core` and a variable-latency external memory and I/O port bank. It decodes the core's T-state sequence from `state`, `Sync` and `D_out`, and latches the 14-bit address and the cycle type. It issues one memory or I/O transaction per core cycle, drives `READY` to hold the core in WAIT until read data arrives, and presents the returned byte on the core's `D_in`.

---
 rtl/i8008_bus_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_i8008_bus_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i8008_bus_ctrl.sv
// rtl/i8008_bus_ctrl.sv - 8008 bus-cycle controller for variable-latency memory and I/O ports
// Optional ack timeout with sticky bus_err is enabled by defining BUSCTL_TIMEOUT_EN.
package i8008_pkg;
  typedef enum logic [2:0] {
    TWAIT = 3'b000,
    T3    = 3'b001,
    T1    = 3'b010,
    TSTOP = 3'b011,
    T2    = 3'b100,
    T5    = 3'b101,
    T1I   = 3'b110,
    T4    = 3'b111
  } state_t;
endpackage

module i8008_bus_ctrl
  import i8008_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  logic              Sync,
  input  logic [7:0]        D_out,
  output logic [7:0]        D_in,
  output logic              READY,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              io_stb,
  output logic [4:0]        io_port,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DONE = 3'd2,
    S_WR_ARM  = 3'd3,
    S_WR_REQ  = 3'd4,
    S_IO      = 3'd5
  } fsm_t;

  localparam logic [1:0] CT_PCI = 2'b00;
  localparam logic [1:0] CT_PCR = 2'b01;
  localparam logic [1:0] CT_PCC = 2'b10;
  localparam logic [1:0] CT_PCW = 2'b11;

  fsm_t        r_state;
  fsm_t        w_state_nxt;
  logic [7:0]  r_addr_lo;
  logic [5:0]  r_addr_hi;
  logic [1:0]  r_type;
  logic        r_pend;
  logic [7:0]  r_d_in;
  logic        r_ready;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_io_stb;
  logic [4:0]  r_io_port;
  logic [7:0]  r_io_wdata;

  logic        w_t1;
  logic        w_t2;
  logic        w_t3;
  logic        w_start;
  logic        w_tmo;
  logic [1:0]  w_type_cur;
  logic [13:0] w_addr14;
  logic        w_ready_nxt;
  logic        w_req_nxt;
  logic        w_we_nxt;

  // Sync qualifies the clock in which the core's state code is valid.
  assign w_t1 = Sync && (state == T1);
  assign w_t2 = Sync && (state == T2);
  assign w_t3 = Sync && (state == T3);

  // A cycle latched during an outstanding write is started from IDLE via r_pend.
  assign w_start    = (r_state == S_IDLE) && (w_t2 || r_pend);
  assign w_type_cur = w_t2 ? D_out[7:6] : r_type;
  assign w_addr14   = {(w_t2 ? D_out[5:0] : r_addr_hi), r_addr_lo};

`ifdef BUSCTL_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_bus_err;
  logic       w_in_req;

  assign w_in_req = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign w_tmo    = w_in_req && !mem_ack && (r_tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_in_req && !mem_ack && !w_tmo) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      else                                r_tmo_cnt <= 8'd0;
      if (w_tmo) r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          case (w_type_cur)
            CT_PCI, CT_PCR: w_state_nxt = S_RD_REQ;
            CT_PCW:         w_state_nxt = S_WR_ARM;
            default:        w_state_nxt = S_IO;
          endcase
        end
      end
      S_RD_REQ:  if (mem_ack || w_tmo) w_state_nxt = S_RD_DONE;
      S_RD_DONE: if (w_t3) w_state_nxt = S_IDLE;
      S_WR_ARM:  if (w_t3) w_state_nxt = S_WR_REQ;
      S_WR_REQ:  if (mem_ack || w_tmo) w_state_nxt = S_IDLE;
      S_IO:      if (w_t3) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = 1'b0;
    w_req_nxt   = 1'b0;
    w_we_nxt    = 1'b0;
    case (w_state_nxt)
      S_RD_REQ:  w_req_nxt   = 1'b1;
      S_RD_DONE: w_ready_nxt = 1'b1;
      S_WR_ARM:  w_ready_nxt = 1'b1;
      S_WR_REQ: begin
        w_req_nxt = 1'b1;
        w_we_nxt  = 1'b1;
      end
      S_IO:      w_ready_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_lo   <= 8'd0;
      r_addr_hi   <= 6'd0;
      r_type      <= CT_PCI;
      r_pend      <= 1'b0;
      r_d_in      <= 8'd0;
      r_ready     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
      r_io_stb    <= 1'b0;
      r_io_port   <= 5'd0;
      r_io_wdata  <= 8'd0;
    end else begin
      if (w_t1) r_addr_lo <= D_out;
      if (w_t2) begin
        r_addr_hi <= D_out[5:0];
        r_type    <= D_out[7:6];
      end

      if (w_start)                          r_pend <= 1'b0;
      else if (w_t2 && r_state != S_IDLE)   r_pend <= 1'b1;

      r_ready   <= w_ready_nxt;
      r_mem_req <= w_req_nxt;
      r_mem_we  <= w_we_nxt;

      if (w_start) r_mem_addr <= ADDR_W'(w_addr14);
      if (r_state == S_WR_ARM && w_t3) r_mem_wdata <= D_out;

      r_io_stb <= (r_state == S_IDLE) && (w_state_nxt == S_IO);
      if (r_state == S_IDLE && w_state_nxt == S_IO) begin
        r_io_port  <= w_addr14[13:9];
        r_io_wdata <= r_addr_lo;
      end

      if (r_state == S_RD_REQ && mem_ack)    r_d_in <= mem_rdata;
      else if (r_state == S_RD_REQ && w_tmo) r_d_in <= 8'h00;
      else if (r_io_stb)                     r_d_in <= io_rdata;
    end
  end

  assign D_in      = r_d_in;
  assign READY     = r_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign io_stb    = r_io_stb;
  assign io_port   = r_io_port;
  assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// tb/tb_i8008_bus_ctrl.sv - directed self-checking bench for i8008_bus_ctrl
module tb_i8008_bus_ctrl;
  import i8008_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  state_t      state;
  logic        Sync;
  logic [7:0]  D_out;
  logic [7:0]  D_in;
  logic        READY;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        io_stb;
  logic [4:0]  io_port;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int waits;

  always #5 clk = ~clk;

  i8008_bus_ctrl #(.ADDR_W(14), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .state(state), .Sync(Sync), .D_out(D_out),
    .D_in(D_in), .READY(READY), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .io_stb(io_stb), .io_port(io_port),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input state_t s, input logic [7:0] d);
    state = s;
    D_out = d;
    step();
  endtask

  // Core in WAIT: leaves after a cycle in which READY was high; bounded.
  task automatic run_wait(input int ack_at, input logic [7:0] rd, output int n);
    logic rdy;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      state     = TWAIT;
      mem_ack   = (k == ack_at);
      mem_rdata = rd;
      rdy       = READY;
      n++;
      step();
      mem_ack = 1'b0;
      if (rdy) break;
    end
  endtask

  initial begin
    rst = 1'b1; Sync = 1'b1; state = T1I; D_out = 8'h00;
    mem_rdata = 8'h00; mem_ack = 1'b0; io_rdata = 8'h00;
    step(); step();
    chk("rst_din", D_in, 0);       chk("rst_ready", READY, 0);
    chk("rst_req", mem_req, 0);    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);  chk("rst_wdata", mem_wdata, 0);
    chk("rst_stb", io_stb, 0);     chk("rst_port", io_port, 0);
    chk("rst_iow", io_wdata, 0);   chk("rst_err", bus_err, 0);
    rst = 1'b0;
    step();

    // Fetch at 0x0012, ack in third request cycle
    cyc(T1, 8'h12);
    cyc(T2, 8'h00);
    chk("fetch_req", mem_req, 1);
    chk("fetch_we", mem_we, 0);
    chk("fetch_addr", mem_addr, 14'h0012);
    chk("fetch_ready0", READY, 0);
    run_wait(3, 8'h08, waits);
    chk("fetch_waits", waits, 4);
    chk("fetch_din", D_in, 8'h08);
    chk("fetch_ready_t3", READY, 1);
    chk("fetch_req_fall", mem_req, 0);
    cyc(T3, 8'h00);
    chk("fetch_ready_after", READY, 0);
    chk("fetch_din_hold", D_in, 8'h08);

    // PCR read at 0x3F99, ack in first request cycle
    cyc(T1, 8'h99);
    cyc(T2, 8'h7F);
    chk("pcr_addr", mem_addr, 14'h3F99);
    run_wait(1, 8'hB4, waits);
    chk("pcr_waits", waits, 2);
    chk("pcr_din", D_in, 8'hB4);
    cyc(T3, 8'h00);

    // Write to 0x0534 with data 0xA7
    cyc(T1, 8'h34);
    cyc(T2, 8'hC5);
    chk("wr_ready_early", READY, 1);
    chk("wr_req_armed", mem_req, 0);
    cyc(TWAIT, 8'h00);
    cyc(T3, 8'hA7);
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 14'h0534);
    chk("wr_wdata", mem_wdata, 8'hA7);
    chk("wr_ready_off", READY, 0);
    state = T4; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_req_fall", mem_req, 0);
    chk("wr_we_fall", mem_we, 0);

    // Back-to-back: write ack in 6th request cycle, fetch T2 arrives meanwhile
    cyc(T1, 8'h00);
    cyc(T2, 8'hC2);
    cyc(TWAIT, 8'h00);
    cyc(T3, 8'h5A);
    chk("b2b_wr_req", mem_req, 1);
    cyc(T1, 8'h40);
    cyc(T2, 8'h01);
    for (int i = 5; i <= 9; i++) begin
      state   = TWAIT;
      mem_ack = (i == 8);
      chk($sformatf("b2b_ready_c%0d", i), READY, 0);
      chk($sformatf("b2b_req_c%0d", i), mem_req, (i <= 8) ? 1 : 0);
      step();
      mem_ack = 1'b0;
    end
    chk("b2b_rd_req", mem_req, 1);
    chk("b2b_rd_we", mem_we, 0);
    chk("b2b_rd_addr", mem_addr, 14'h0140);
    chk("b2b_wdata_kept", mem_wdata, 8'h5A);
    state = TWAIT; mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    chk("b2b_ready", READY, 1);
    chk("b2b_din", D_in, 8'h77);
    cyc(TWAIT, 8'h00);
    cyc(T3, 8'h00);
    chk("b2b_ready_after", READY, 0);

    // Stray ack while idle is ignored
    state = T4; mem_ack = 1'b1; mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0;
    chk("stray_req", mem_req, 0);
    chk("stray_din", D_in, 8'h77);

    // STOPPED and T1I never start a transaction
    cyc(TSTOP, 8'h00);
    cyc(T1I, 8'h00);
    cyc(TSTOP, 8'h00);
    chk("stop_req", mem_req, 0);
    chk("stop_ready", READY, 0);

    // I/O cycle
    io_rdata = 8'h55;
    cyc(T1, 8'h3C);
    cyc(T2, 8'h8E);
    chk("io_stb", io_stb, 1);
    chk("io_port", io_port, 5'd7);
    chk("io_wdata", io_wdata, 8'h3C);
    chk("io_ready", READY, 1);
    chk("io_noreq", mem_req, 0);
    cyc(TWAIT, 8'h00);
    chk("io_stb_once", io_stb, 0);
    chk("io_din", D_in, 8'h55);
    cyc(T3, 8'h00);
    chk("io_stb_idle", io_stb, 0);
    chk("io_ready_after", READY, 0);

    // Reset during RD_REQ then a late ack
    cyc(T1, 8'h21);
    cyc(T2, 8'h40);
    chk("rr_req", mem_req, 1);
    rst = 1'b1; state = TWAIT;
    step();
    rst = 1'b0;
    chk("rr_req_drop", mem_req, 0);
    chk("rr_din0", D_in, 0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    chk("rr_late_req", mem_req, 0);
    chk("rr_late_din", D_in, 0);
    chk("rr_late_ready", READY, 0);
    step();
    chk("rr_idle_req", mem_req, 0);

`ifdef BUSCTL_TIMEOUT_EN
    begin
      int nreq;
      nreq = 0;
      cyc(T1, 8'h12);
      cyc(T2, 8'h00);
      for (int k = 1; k <= 16; k++) begin
        state = TWAIT;
        if (mem_req) nreq++;
        step();
      end
      chk("tmo_req_cycles", nreq, 16);
      chk("tmo_din", D_in, 8'h00);
      chk("tmo_ready", READY, 1);
      chk("tmo_err", bus_err, 1);
      chk("tmo_req_fall", mem_req, 0);
      cyc(T3, 8'h00);
      cyc(T4, 8'h00);
      chk("tmo_err_sticky", bus_err, 1);
    end
`else
    chk("no_tmo_err", bus_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
